// File: rtl/sterownik_pkg.sv
// Shared types for the shift-register command sequencer: operation codes,
// sequencer states and the command record carried through the queue.
package sterownik_pkg;

  // Default geometry of the sequencer and the register it drives
  localparam int WIDTH_DEF      = 4;
  localparam int CNT_W_DEF      = 4;
  localparam int FIFO_DEPTH_DEF = 4;

  // Operation codes double as the register's {S1,S0} mode selects
  typedef enum logic [1:0] {
    OP_HOLD  = 2'b00,
    OP_RIGHT = 2'b01,
    OP_LEFT  = 2'b10,
    OP_LOAD  = 2'b11
  } op_t;

  // Sequencer states
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // One queued command at the default geometry, packed as {op, data, len}
  typedef struct packed {
    op_t                  op;
    logic [WIDTH_DEF-1:0] data;
    logic [CNT_W_DEF-1:0] len;
  } cmd_t;

endpackage

// File: rtl/kolejka_polecen.sv
// Command queue: small synchronous FIFO with registered pointers, a
// combinational head read and a synchronous flush. No fall-through: an
// entry becomes visible at the head on the edge after it is written.
module kolejka_polecen
  import sterownik_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH_DEF,
  parameter int DW    = 2 + WIDTH_DEF + CNT_W_DEF
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          flush,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] data_in,
  output logic [DW-1:0] data_out,
  output logic          full,
  output logic          empty
);

  localparam int AW = $clog2(DEPTH);

  // NOTE: the storage array has no reset; pointers and count alone define
  // which entries are valid, so stale contents are never observed.
  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  // A full queue refuses pushes even if it pops in the same edge
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign data_out = mem[rd_ptr];

  // Write accepted commands at the tail
  always_ff @(posedge CLK) begin
    if (do_push) begin
      mem[wr_ptr] <= data_in;
    end
  end

  // Pointer and occupancy bookkeeping; reset and flush both empty the queue
  always_ff @(posedge CLK) begin
    // NOTE: state registers use non-blocking assignments so every block
    // sees the pre-edge values regardless of evaluation order.
    if (RST || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/sterownik_rejestru.sv
// Command sequencer for the 4-bit universal shift register. Commands
// {op, data, len} arrive over valid/ready, are queued, and each one drives
// the register's mode selects for max(len,1) consecutive edges before a
// one-cycle DONE pulse. Consecutive commands run back-to-back with no hold
// gap. ABORT flushes everything; reset additionally clears the data bus.
module sterownik_rejestru
  import sterownik_pkg::*;
#(
  parameter int WIDTH      = WIDTH_DEF,
  parameter int CNT_W      = CNT_W_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CMD_VALID,
  output logic             CMD_READY,
  input  logic [1:0]       CMD_OP,
  input  logic [WIDTH-1:0] CMD_DATA,
  input  logic [CNT_W-1:0] CMD_LEN,
  input  logic             ABORT,
  output logic             S0,
  output logic             S1,
  output logic [WIDTH-1:0] I,
  output logic             BUSY,
  output logic             DONE
);

  localparam int ENTRY_W = 2 + WIDTH + CNT_W;

  state_t             state;
  op_t                sel;
  logic [CNT_W-1:0]   cnt;

  logic               fifo_push;
  logic               fifo_pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic [ENTRY_W-1:0] fifo_din;
  logic [ENTRY_W-1:0] fifo_dout;

  op_t                head_op;
  logic [WIDTH-1:0]   head_data;
  logic [CNT_W-1:0]   head_len;
  logic [CNT_W-1:0]   head_cnt;

  // A push coinciding with ABORT is dropped; reset drops it inside the queue
  assign fifo_push = CMD_VALID && !ABORT;
  assign fifo_din  = {CMD_OP, CMD_DATA, CMD_LEN};
  assign CMD_READY = !fifo_full;

  // Unpack the head entry; a zero length still applies the op once
  assign head_op   = op_t'(fifo_dout[ENTRY_W-1 -: 2]);
  assign head_data = fifo_dout[CNT_W +: WIDTH];
  assign head_len  = fifo_dout[CNT_W-1:0];
  assign head_cnt  = (head_len == '0) ? '0 : head_len - 1'b1;

  assign {S1, S0}  = sel;

  kolejka_polecen #(
    .DEPTH (FIFO_DEPTH),
    .DW    (ENTRY_W)
  ) u_kolejka (
    .CLK      (CLK),
    .RST      (RST),
    .flush    (ABORT),
    .push     (fifo_push),
    .pop      (fifo_pop),
    .data_in  (fifo_din),
    .data_out (fifo_dout),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // Take the next command when idle or when the current one ends this edge
  always_comb begin
    // NOTE: default first so every path assigns and no latch is inferred.
    fifo_pop = 1'b0;
    if (!RST && !ABORT && !fifo_empty) begin
      if (state == IDLE || cnt == '0) begin
        fifo_pop = 1'b1;
      end
    end
  end

  // Sequencer: registered selects, data, busy/done and remaining-edge count
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      sel   <= OP_HOLD;
      I     <= '0;
      cnt   <= '0;
      BUSY  <= 1'b0;
      DONE  <= 1'b0;
    end else if (ABORT) begin
      state <= IDLE;
      sel   <= OP_HOLD;
      cnt   <= '0;
      BUSY  <= 1'b0;
      DONE  <= 1'b0;
    end else begin
      DONE <= 1'b0;
      if (state == RUN && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end else begin
        // Last edge of a running command reports completion
        if (state == RUN) DONE <= 1'b1;
        if (fifo_pop) begin
          sel   <= head_op;
          I     <= head_data;
          cnt   <= head_cnt;
          BUSY  <= 1'b1;
          state <= RUN;
        end else begin
          // Park on hold; I keeps the last command's data
          sel   <= OP_HOLD;
          BUSY  <= 1'b0;
          state <= IDLE;
        end
      end
    end
  end

endmodule

// File: tb/tb_sterownik_rejestru.sv
// Bench for the shift-register command sequencer. A command-level model
// (queue of accepted commands, active command with edges remaining) predicts
// every output each cycle; directed literal checks pin the model.
module tb_sterownik_rejestru;
  import sterownik_pkg::*;

  localparam int DEPTH = 4;

  logic       CLK = 1'b0;
  logic       RST;
  logic       CMD_VALID;
  logic       CMD_READY;
  logic [1:0] CMD_OP;
  logic [3:0] CMD_DATA;
  logic [3:0] CMD_LEN;
  logic       ABORT;
  logic       S0;
  logic       S1;
  logic [3:0] I;
  logic       BUSY;
  logic       DONE;

  always #5 CLK = ~CLK;

  sterownik_rejestru #(
    .WIDTH      (4),
    .CNT_W      (4),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .CMD_VALID (CMD_VALID),
    .CMD_READY (CMD_READY),
    .CMD_OP    (CMD_OP),
    .CMD_DATA  (CMD_DATA),
    .CMD_LEN   (CMD_LEN),
    .ABORT     (ABORT),
    .S0        (S0),
    .S1        (S1),
    .I         (I),
    .BUSY      (BUSY),
    .DONE      (DONE)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // ---------------- command-level model ----------------
  cmd_t       mq[$];
  bit         m_live   = 1'b0;
  bit         m_active = 1'b0;
  bit         m_done   = 1'b0;
  op_t        m_op     = OP_HOLD;
  logic [3:0] m_data;
  int         m_left   = 0;

  always @(posedge CLK) begin
    int   sz;
    bit   acc;
    cmd_t c;
    sz  = mq.size();
    acc = (CMD_VALID === 1'b1) && (sz < DEPTH);
    if (RST === 1'b1) begin
      mq.delete();
      m_active = 1'b0;
      m_done   = 1'b0;
      m_data   = 4'h0;
      m_live   = 1'b1;
    end else if (ABORT === 1'b1) begin
      mq.delete();
      m_active = 1'b0;
      m_done   = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_active) begin
        m_left--;
        if (m_left == 0) begin
          m_active = 1'b0;
          m_done   = 1'b1;
        end
      end
      if (!m_active && mq.size() > 0) begin
        c        = mq.pop_front();
        m_active = 1'b1;
        m_op     = c.op;
        m_data   = c.data;
        m_left   = (c.len == 4'd0) ? 1 : int'(c.len);
      end
      if (acc) mq.push_back(cmd_t'{op: op_t'(CMD_OP), data: CMD_DATA, len: CMD_LEN});
    end
  end

  // Attached 4-bit universal shift register (right = toward LSB, zero fill)
  logic [3:0] sr_q = 4'h0;
  always @(posedge CLK) begin
    case ({S1, S0})
      2'b01:   sr_q <= {1'b0, sr_q[3:1]};
      2'b10:   sr_q <= {sr_q[2:0], 1'b0};
      2'b11:   sr_q <= I;
      default: ;
    endcase
  end

  // Per-cycle comparison of {S1S0, I, BUSY, DONE, READY} against the model
  always @(negedge CLK) begin
    logic [8:0] exp_v;
    if (m_live) begin
      exp_v = {(m_active ? m_op : OP_HOLD), m_data, m_active, m_done, (mq.size() < DEPTH)};
      check("cycle {S1S0,I,BUSY,DONE,READY}", {23'd0, S1, S0, I, BUSY, DONE, CMD_READY}, {23'd0, exp_v});
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n = 1);
    repeat (n) @(negedge CLK);
  endtask

  // Offer a command from a negedge; return at the negedge after acceptance
  // with CMD_VALID still high so the next push can follow back-to-back.
  task automatic push(input logic [1:0] op, input logic [3:0] d, input logic [3:0] len);
    int waited = 0;
    CMD_OP    = op;
    CMD_DATA  = d;
    CMD_LEN   = len;
    CMD_VALID = 1'b1;
    while (CMD_READY !== 1'b1 && waited < 100) begin
      @(negedge CLK);
      waited++;
    end
    check("push accepted within bound", {31'd0, waited < 100}, 32'd1);
    @(negedge CLK);
  endtask

  task automatic wait_idle();
    int waited = 0;
    while (BUSY !== 1'b0 && waited < 300) begin
      @(negedge CLK);
      waited++;
    end
    check("idle within bound", {31'd0, waited < 300}, 32'd1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [2:0] b2b_exp [6];
    b2b_exp = '{3'b010, 3'b010, 3'b010, 3'b101, 3'b100, 3'b001};

    RST = 1'b1; CMD_VALID = 1'b0; ABORT = 1'b0;
    CMD_OP = 2'b00; CMD_DATA = 4'h0; CMD_LEN = 4'h0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    tick();
    check("reset S1S0", {30'd0, S1, S0}, 32'd0);
    check("reset I", {28'd0, I}, 32'd0);
    check("reset BUSY", {31'd0, BUSY}, 32'd0);
    check("reset DONE", {31'd0, DONE}, 32'd0);
    check("reset READY", {31'd0, CMD_READY}, 32'd1);

    // Single load of 1010, LEN=1
    push(2'b11, 4'b1010, 4'd1);
    CMD_VALID = 1'b0;
    check("load cycle k BUSY", {31'd0, BUSY}, 32'd0);
    tick();
    check("load k+1 S1S0", {30'd0, S1, S0}, 32'd3);
    check("load k+1 I", {28'd0, I}, 32'hA);
    check("load k+1 BUSY", {31'd0, BUSY}, 32'd1);
    tick();
    check("load k+2 DONE", {31'd0, DONE}, 32'd1);
    check("load k+2 S1S0", {30'd0, S1, S0}, 32'd0);
    check("load k+2 BUSY", {31'd0, BUSY}, 32'd0);
    check("load shift reg Q", {28'd0, sr_q}, 32'hA);
    tick();
    check("load k+3 DONE", {31'd0, DONE}, 32'd0);

    // Back-to-back right x3 then left x2
    tick(2);
    push(2'b01, 4'h0, 4'd3);
    push(2'b10, 4'h0, 4'd2);
    CMD_VALID = 1'b0;
    for (int i = 0; i < 6; i++) begin
      check($sformatf("b2b {S1S0,DONE}[%0d]", i), {29'd0, S1, S0, DONE}, {29'd0, b2b_exp[i]});
      tick();
    end
    check("b2b shift reg Q", {28'd0, sr_q}, 32'h4);

    // Queue fill: long hold then five more commands
    tick();
    push(2'b00, 4'h0, 4'd15);
    push(2'b01, 4'h1, 4'd1);
    push(2'b10, 4'h2, 4'd2);
    push(2'b11, 4'h3, 4'd3);
    push(2'b01, 4'h4, 4'd1);
    check("full READY", {31'd0, CMD_READY}, 32'd0);
    check("full BUSY", {31'd0, BUSY}, 32'd1);
    push(2'b10, 4'h5, 4'd2);
    CMD_VALID = 1'b0;
    wait_idle();

    // LEN=0 load of 0101 applies once
    tick();
    push(2'b11, 4'b0101, 4'd0);
    CMD_VALID = 1'b0;
    tick();
    check("len0 S1S0", {30'd0, S1, S0}, 32'd3);
    check("len0 I", {28'd0, I}, 32'h5);
    tick();
    check("len0 DONE", {31'd0, DONE}, 32'd1);
    check("len0 S1S0 after", {30'd0, S1, S0}, 32'd0);
    check("len0 shift reg Q", {28'd0, sr_q}, 32'h5);
    tick();
    check("len0 single DONE", {31'd0, DONE}, 32'd0);

    // ABORT in the 2nd cycle of a right x5 with two queued, plus a push
    tick();
    push(2'b01, 4'h9, 4'd5);
    push(2'b10, 4'h6, 4'd2);
    push(2'b11, 4'h7, 4'd1);
    check("abort pre S1S0", {30'd0, S1, S0}, 32'd1);
    CMD_OP = 2'b11; CMD_DATA = 4'hF; CMD_LEN = 4'd1;
    ABORT = 1'b1;
    tick();
    ABORT = 1'b0; CMD_VALID = 1'b0;
    check("abort S1S0", {30'd0, S1, S0}, 32'd0);
    check("abort BUSY", {31'd0, BUSY}, 32'd0);
    check("abort DONE", {31'd0, DONE}, 32'd0);
    check("abort READY", {31'd0, CMD_READY}, 32'd1);
    check("abort I kept", {28'd0, I}, 32'h9);
    tick(3);
    check("abort queue empty", {31'd0, BUSY}, 32'd0);

    // Same scenario with RST
    push(2'b01, 4'h9, 4'd5);
    push(2'b10, 4'h6, 4'd2);
    push(2'b11, 4'h7, 4'd1);
    CMD_OP = 2'b11; CMD_DATA = 4'hF; CMD_LEN = 4'd1;
    RST = 1'b1;
    tick();
    RST = 1'b0; CMD_VALID = 1'b0;
    check("rst mid S1S0", {30'd0, S1, S0}, 32'd0);
    check("rst mid I", {28'd0, I}, 32'd0);
    check("rst mid BUSY", {31'd0, BUSY}, 32'd0);
    check("rst mid DONE", {31'd0, DONE}, 32'd0);
    check("rst mid READY", {31'd0, CMD_READY}, 32'd1);
    tick(3);
    check("rst queue empty", {31'd0, BUSY}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Hard time limit
  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by 200000 required finish earlier");
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $fatal(1, "timeout");
  end

endmodule
